mig_port_arbiter: RTL

- Shares one MIG user port among N_CH APB-to-MIG requesters in the ui_clk domain.
- Round-robin arbitration of read and write requests into a registered MIG request stage.
- Tracks up to MAX_OUTSTANDING in-flight reads and routes in-order read data back to the originating channel.
- Parametrised successor of the single-channel APB/MIG link: generalises channel count, widths and read depth; adds arbitration, read routing and error flagging.

---
 rtl/apb_mig_pkg.sv | 28 ++
 rtl/mig_tag_fifo.sv | 68 ++++++
 rtl/mig_port_arbiter.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/apb_mig_pkg.sv
// Shared types and defaults for the APB/MIG link and the multi-channel MIG port arbiter.
// Types here are sized for the default build; parametrised modules derive their own widths.
package apb_mig_pkg;

  localparam int N_CH_DEF            = 4;
  localparam int MAX_OUTSTANDING_DEF = 8;
  localparam int DATA_W_DEF          = 128;
  localparam int STRB_W_DEF          = DATA_W_DEF / 8;
  localparam int ADDR_W_DEF          = 27;

  typedef logic [DATA_W_DEF-1:0]        data_t;
  typedef logic [STRB_W_DEF-1:0]        strb_t;
  typedef logic [ADDR_W_DEF-1:0]        mig_addr_t;
  typedef logic [$clog2(N_CH_DEF)-1:0]  ch_id_t;

  typedef struct packed {
    logic      w_en;
    mig_addr_t addr;
    data_t     data;
    strb_t     strb;
  } mig_req_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } arb_state_e;

endpackage

// File: rtl/mig_tag_fifo.sv
// Synchronous FIFO of channel tags: head visible combinationally, push/pop take effect at the edge.
// Push while full is dropped unless a pop frees the slot in the same cycle; pop while empty is ignored.
module mig_tag_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_dat_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    do_pop   = pop_i && !empty_o;
    do_push  = push_i && (!full_o || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_dat_i;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/mig_port_arbiter.sv
// Round-robin sharing of one MIG user port among N_CH requesters; grant is combinational, the MIG request is registered.
// A held request stalls until MIG accepts it; read data returns in order and is steered by a tag FIFO.
module mig_port_arbiter
  import apb_mig_pkg::*;
#(
  parameter int N_CH            = N_CH_DEF,
  parameter int DATA_W          = DATA_W_DEF,
  parameter int ADDR_W          = ADDR_W_DEF,
  parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF
) (
  input  logic                     ui_clk_i,
  input  logic                     ui_reset_ni,
  input  logic [N_CH-1:0]          ch_en_i,
  input  logic [N_CH-1:0]          ch_w_en_i,
  input  logic [N_CH*ADDR_W-1:0]   ch_addr_i,
  input  logic [N_CH*DATA_W-1:0]   ch_data_i,
  input  logic [N_CH*DATA_W/8-1:0] ch_strb_i,
  output logic [N_CH-1:0]          ch_ready_o,
  output logic [N_CH-1:0]          ch_valid_o,
  output logic [DATA_W-1:0]        ch_data_o,
  output logic                     mig_en_o,
  output logic                     mig_w_en_o,
  output logic [ADDR_W-1:0]        mig_addr_o,
  output logic [DATA_W-1:0]        mig_data_o,
  output logic [DATA_W/8-1:0]      mig_strb_o,
  input  logic                     mig_ready_i,
  input  logic                     mig_w_ready_i,
  input  logic                     mig_valid_i,
  input  logic [DATA_W-1:0]        mig_data_i,
  output logic                     err_o
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CH_W   = $clog2(N_CH);
  localparam int CNT_W  = $clog2(MAX_OUTSTANDING) + 1;

  typedef logic [CH_W-1:0] ch_idx_t;

  // Same layout as mig_req_t, but sized by this instance's parameters.
  typedef struct packed {
    logic              w_en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
  } req_t;

  arb_state_e state_q, state_d;
  req_t       req_q, req_d;
  ch_idx_t    rr_q, rr_d;
  logic       err_q, err_d;

  logic            accept, latch_ok, read_room;
  logic [N_CH-1:0] elig;
  logic            grant_vld;
  ch_idx_t         grant_id, cand;
  req_t            grant_req;
  logic            tag_push, tag_pop;
  ch_idx_t         tag_head;
  logic [CNT_W-1:0] tag_cnt;
  logic            tag_full, tag_empty;

  assign read_room = (tag_cnt < CNT_W'(MAX_OUTSTANDING));
  assign accept    = (state_q == ST_ISSUE) && mig_ready_i && (!req_q.w_en || mig_w_ready_i);
  assign latch_ok  = (state_q == ST_IDLE) || accept;

  always_comb begin
    elig      = '0;
    grant_vld = 1'b0;
    grant_id  = '0;
    cand      = '0;
    for (int k = 0; k < N_CH; k++) begin
      elig[k] = ch_en_i[k] && (ch_w_en_i[k] || read_room);
    end
    for (int i = 1; i <= N_CH; i++) begin
      cand = ch_idx_t'((int'(rr_q) + i) % N_CH);
      if (!grant_vld && elig[cand]) begin
        grant_vld = 1'b1;
        grant_id  = cand;
      end
    end
  end

  always_comb begin
    grant_req  = '0;
    ch_ready_o = '0;
    ch_valid_o = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (grant_id == ch_idx_t'(k)) begin
        grant_req.w_en = ch_w_en_i[k];
        grant_req.addr = ch_addr_i[k*ADDR_W +: ADDR_W];
        grant_req.data = ch_data_i[k*DATA_W +: DATA_W];
        grant_req.strb = ch_strb_i[k*STRB_W +: STRB_W];
      end
      ch_ready_o[k] = latch_ok && grant_vld && (grant_id == ch_idx_t'(k));
      ch_valid_o[k] = tag_pop && (tag_head == ch_idx_t'(k));
    end
  end

  assign tag_push  = latch_ok && grant_vld && !grant_req.w_en && !tag_full;
  assign tag_pop   = mig_valid_i && !tag_empty;
  assign ch_data_o = mig_data_i;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    rr_d    = rr_q;
    err_d   = err_q || (mig_valid_i && tag_empty);
    if (latch_ok) begin
      if (grant_vld) begin
        state_d = ST_ISSUE;
        req_d   = grant_req;
        rr_d    = grant_id;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge ui_clk_i) begin
    if (!ui_reset_ni) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      rr_q    <= ch_idx_t'(N_CH - 1);
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      rr_q    <= rr_d;
      err_q   <= err_d;
    end
  end

  mig_tag_fifo #(
    .WIDTH (CH_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk_i      (ui_clk_i),
    .rst_ni     (ui_reset_ni),
    .push_i     (tag_push),
    .push_dat_i (grant_id),
    .pop_i      (tag_pop),
    .head_o     (tag_head),
    .count_o    (tag_cnt),
    .full_o     (tag_full),
    .empty_o    (tag_empty)
  );

  assign mig_en_o   = (state_q == ST_ISSUE);
  assign mig_w_en_o = req_q.w_en;
  assign mig_addr_o = req_q.addr;
  assign mig_data_o = req_q.data;
  assign mig_strb_o = req_q.strb;
  assign err_o      = err_q;

endmodule
